// File: rtl/audio_bram_pkg.sv
// Types and helpers shared by the audio BRAM port arbiter and its read-tag pipeline.
// Ports are numbered by priority: the I2S DMA always wins a plain conflict.
package audio_bram_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] bram_addr_t;
    typedef logic [31:0] bram_data_t;
    typedef logic [3:0]  bram_we_t;

    typedef enum logic {
        PORT_I2S   = 1'b0,
        PORT_SYNTH = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } rd_tag_t;

    function automatic bram_addr_t word_align(input bram_addr_t addr);
        return addr & ~bram_addr_t'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Delay line that carries {valid, port} for each issued read so the tag lines up
// with BRAM_dout; the whole line is flushed by reset so in-flight reads vanish.
module bram_rd_tag_pipe
    import audio_bram_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rstn,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-master arbiter for one BRAM port: I2S DMA has priority, the synth writer is
// forced through after MAX_WAIT consecutive denials. All BRAM pins are registered.
module bram_port_arbiter
    import audio_bram_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rstn,

    input  logic             m0_req,
    input  logic [3:0]       m0_we,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [31:0]      m0_rdata,

    input  logic             m1_req,
    input  logic [3:0]       m1_we,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,

    output logic [31:0]      BRAM_addr,
    output logic             BRAM_clk,
    output logic [31:0]      BRAM_din,
    input  logic [31:0]      BRAM_dout,
    output logic             BRAM_en,
    output logic             BRAM_rst,
    output logic [3:0]       BRAM_we,

    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  conflict_cnt_q;
    logic              starve;
    logic              gnt0, gnt1, any_gnt;
    bram_addr_t        sel_addr;
    bram_data_t        sel_wdata;
    bram_we_t          sel_we;

    logic              en_q;
    bram_we_t          we_q;
    bram_addr_t        addr_q;
    bram_data_t        din_q;
    logic              bram_rst_q;
    rd_tag_t           iss_tag_d, iss_tag_q, ret_tag;

    logic              rvalid0_q, rvalid1_q;
    bram_data_t        rdata0_q, rdata1_q;

    // Grants are purely combinational so a master can transfer in its request cycle.
    always_comb begin
        starve = (MAX_WAIT > 0) && (wait_cnt_q >= WAIT_MAX);
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        if (rstn) begin
            if (m0_req && !(m1_req && starve)) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
        end
        any_gnt   = gnt0 | gnt1;
        sel_addr  = gnt1 ? m1_addr  : m0_addr;
        sel_wdata = gnt1 ? m1_wdata : m0_wdata;
        sel_we    = gnt1 ? m1_we    : m0_we;

        iss_tag_d.valid = any_gnt && (sel_we == '0);
        iss_tag_d.port  = gnt1 ? PORT_SYNTH : PORT_I2S;

        if (!m1_req || gnt1) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_q     <= '0;
            conflict_cnt_q <= '0;
            bram_rst_q     <= 1'b1;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bram_rst_q <= 1'b0;
            if (m0_req && m1_req && (conflict_cnt_q != '1)) begin
                conflict_cnt_q <= conflict_cnt_q + 1'b1;
            end
        end
    end

    // Address and write data only move on a grant; idle cycles just drop en/we.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q      <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            iss_tag_q <= '0;
        end else begin
            en_q      <= any_gnt;
            we_q      <= any_gnt ? sel_we : '0;
            iss_tag_q <= iss_tag_d;
            if (any_gnt) begin
                addr_q <= word_align(sel_addr);
                din_q  <= sel_wdata;
            end
        end
    end

    bram_rd_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rstn  (rstn),
        .tag_i (iss_tag_q),
        .tag_o (ret_tag)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= ret_tag.valid && (ret_tag.port == PORT_I2S);
            rvalid1_q <= ret_tag.valid && (ret_tag.port == PORT_SYNTH);
            if (ret_tag.valid && (ret_tag.port == PORT_I2S)) begin
                rdata0_q <= BRAM_dout;
            end
            if (ret_tag.valid && (ret_tag.port == PORT_SYNTH)) begin
                rdata1_q <= BRAM_dout;
            end
        end
    end

    assign m0_gnt       = gnt0;
    assign m1_gnt       = gnt1;
    assign m0_rvalid    = rvalid0_q;
    assign m1_rvalid    = rvalid1_q;
    assign m0_rdata     = rdata0_q;
    assign m1_rdata     = rdata1_q;
    assign BRAM_addr    = addr_q;
    assign BRAM_clk     = clk;
    assign BRAM_din     = din_q;
    assign BRAM_en      = en_q;
    assign BRAM_rst     = bram_rst_q;
    assign BRAM_we      = we_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one BRAM port between two requesters: the I2S playback DMA (port 0, real-time, high priority) and the synth sample writer (port 1, low priority, starvation-protected).
- Sits between those masters and the block-design BRAM port and drives the BRAM_* pins.
- All BRAM signals are registered. Read data is tagged and returned only to the requester that issued the read.

Parameters:
- READ_LATENCY, 1, cycles from BRAM_en to valid BRAM_dout (1..3).
- MAX_WAIT, 8, consecutive denied cycles on port 1 before it is forced to win (0 = pure fixed priority).
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  system clock (FCLK).
- rstn  in  1  asynchronous, active-low reset.
- m0_req  in  1  port 0 access request; hold with stable fields until granted.
- m0_we  in  4  port 0 byte write enables; 0 = read.
- m0_addr  in  32  port 0 byte address.
- m0_wdata  in  32  port 0 write data.
- m0_gnt  out  1  port 0 grant (combinational); transfer occurs when m0_req && m0_gnt.
- m0_rvalid  out  1  port 0 read data valid, one-cycle pulse.
- m0_rdata  out  32  port 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- BRAM_addr  out  32  word-aligned byte address.
- BRAM_clk  out  1  equals clk.
- BRAM_din  out  32  write data to BRAM.
- BRAM_dout  in  32  read data from BRAM.
- BRAM_en  out  1  access strobe.
- BRAM_rst  out  1  high while rstn is low.
- BRAM_we  out  4  byte write enables to BRAM.
- conflict_cnt  out  CNT_W  saturating count of cycles with both requests high.

Behaviour:
- Reset (async, rstn=0):
  - Outputs: BRAM_en=0, BRAM_we=0, BRAM_addr=0, BRAM_din=0, all gnt=0, all rvalid=0, rdata=0.
  - State: wait_cnt=0, conflict_cnt=0, read tag pipeline flushed.
  - BRAM_rst=1; it drops on the first clk edge after rstn rises.
- Grant logic (combinational from req and registered wait_cnt; at most one gnt per cycle):
  - Only one requester: that requester is granted.
  - Both requesting, and MAX_WAIT=0 or wait_cnt<MAX_WAIT: port 0 granted.
  - Both requesting, MAX_WAIT>0 and wait_cnt>=MAX_WAIT: port 1 granted.
  - Neither requesting: no grant.
- wait_cnt:
  - Increments on each cycle with m1_req && !m1_gnt, saturating at MAX_WAIT.
  - Clears on an m1 grant, or on any cycle with m1_req=0.
- Issue (registered, cycle N+1 after a grant in cycle N):
  - BRAM_en=1; BRAM_addr={addr[31:2],2'b00}; BRAM_din=wdata; BRAM_we=we.
  - With no grant in cycle N: BRAM_en=0 and BRAM_we=0; addr and din hold their previous values.
- Throughput: back-to-back grants give one access per cycle; no idle cycle is inserted when switching ports.
- Read return:
  - A granted read (we==0) pushes {valid, port} into a READ_LATENCY-deep shift register that advances every cycle.
  - At the output stage, BRAM_dout is registered into the tagged port's rdata and that port's rvalid pulses one cycle.
  - Read issued at grant cycle N returns rvalid in cycle N+1+READ_LATENCY+1 (N+3 at default).
  - rdata of a port holds its value until that port's next read return.
- Writes produce no rvalid.
- Read-after-write to the same address by either port returns the new data. This follows from in-order issue; BRAM port mode is WRITE_FIRST/READ_FIRST-independent because issues are serialized.
- conflict_cnt increments on m0_req && m1_req and saturates at all-ones.
- Reset mid-operation: in-flight reads are discarded with no rvalid; grants are invalid while rstn=0.
- A requester that drops req before grant is legal; nothing is issued for it.

Decomposition:
- Shared package audio_bram_pkg:
  - Typedefs: bram_addr_t (32), bram_data_t (32), bram_we_t (4).
  - Constants: WORD_BYTES=4 and the port index enum PORT_I2S=0, PORT_SYNTH=1.
- One sub-module, bram_rd_tag_pipe: READ_LATENCY-deep valid/port shift register with flush on reset.

Test Plan:
- Port 0 only, read 0x10 with BRAM preloaded 0xDEADBEEF: m0_gnt same cycle, BRAM_en next cycle, m0_rvalid with 0xDEADBEEF at grant+3, m1_rvalid stays 0.
- Port 1 write 0x0000_0007 with we=4'hF, data 0x1234_5678, then port 0 reads 0x04: BRAM_addr=0x04, BRAM_we=4'hF, then m0_rdata=0x12345678, no m1_rvalid.
- Both requesting continuously, MAX_WAIT=8: port 0 gets 8 grants, port 1 gets the 9th, pattern repeats; conflict_cnt advances by 1 per cycle.
- MAX_WAIT=0, both continuous for 100 cycles: m1_gnt never asserts, conflict_cnt=100.
- Four back-to-back reads alternating ports: BRAM_en high 4 consecutive cycles, rvalid returns to the correct port in issue order with no bubbles.
- Assert rstn low for 1 cycle while 2 reads are in flight: no rvalid afterward, BRAM_en=0, BRAM_rst=1 during reset, conflict_cnt=0.
